vending_machine_param: RTL and testbench

//   Parametrised single-product coin vending controller. Accepts low/high-value coins,

---
 rtl/vending_machine_param.sv | 159 +++++++++++++++
 tb/tb_vending_machine_param.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vending_machine_param.sv
// ---------------------------------------------------------------------------
// vending_machine_param
//   Single-product coin vending controller. Coins of value 1 (p1) and
//   COIN_HI (p5) build up credit. When the credit reaches PRICE a one-cycle
//   dispense pulse fires. Change and cancel refunds are paid out as a train
//   of one-unit c1 pulses, one per cycle, with no gaps.
//
// Ports
//   clk      in   1      rising-edge clock
//   reset_n  in   1      asynchronous active-low reset
//   p1       in   1      1-unit coin pulse, one cycle per coin
//   p5       in   1      COIN_HI-unit coin pulse, one cycle per coin
//   cancel   in   1      refund request pulse
//   dispense out  1      registered one-cycle vend pulse
//   c1       out  1      registered one-cycle pulse per returned unit
//   reject   out  1      registered one-cycle pulse: coin seen but not accepted
//   busy     out  1      high while paying out change or a refund
//   credit   out  CW     current accumulated credit
//   sales    out  CNT_W  items dispensed, wraps modulo 2^CNT_W
// ---------------------------------------------------------------------------
module vending_machine_param #(
    parameter int PRICE   = 3,
    parameter int COIN_HI = 5,
    parameter int CNT_W   = 8,
    localparam int CW     = $clog2(PRICE + COIN_HI + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             p1,
    input  logic             p5,
    input  logic             cancel,
    output logic             dispense,
    output logic             c1,
    output logic             reject,
    output logic             busy,
    output logic [CW-1:0]    credit,
    output logic [CNT_W-1:0] sales
);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_PAYOUT = 1'b1;

    localparam logic [CW-1:0]    CR_ZERO  = {CW{1'b0}};
    localparam logic [CW-1:0]    CR_ONE   = CW'(1);
    localparam logic [CW-1:0]    CR_PRICE = CW'(PRICE);
    localparam logic [CW-1:0]    CR_HI    = CW'(COIN_HI);
    localparam logic [CNT_W-1:0] SALES_ONE = CNT_W'(1);

    logic [0:0]       state_r,      state_n_s;
    logic [CW-1:0]    credit_r,     credit_n_s;
    logic [CW-1:0]    change_cnt_r, change_n_s;
    logic [CNT_W-1:0] sales_r,      sales_n_s;
    logic             dispense_r,   dispense_n_s;
    logic             c1_r,         c1_n_s;
    logic             reject_r,     reject_n_s;

    logic [CW-1:0]    coin_val_s;
    logic [CW-1:0]    sum_s;
    logic [CW-1:0]    chg_s;

    // Next-state and next-output decode for both controller states.
    always_comb begin
        state_n_s    = state_r;
        credit_n_s   = credit_r;
        change_n_s   = change_cnt_r;
        sales_n_s    = sales_r;
        dispense_n_s = 1'b0;
        c1_n_s       = 1'b0;
        reject_n_s   = 1'b0;

        // p1 wins when both coins arrive together; the p5 coin is rejected.
        coin_val_s = p1 ? CR_ONE : CR_HI;
        // Largest sum is PRICE-1+COIN_HI, which always fits in CW bits.
        sum_s      = credit_r + coin_val_s;
        chg_s      = sum_s - CR_PRICE;

        case (state_r)
            ST_IDLE: begin
                if (cancel) begin
                    reject_n_s = p1 | p5;
                    if (credit_r != CR_ZERO) begin
                        // First refund unit goes out immediately; the counter
                        // holds only the units still owed after this pulse.
                        c1_n_s     = 1'b1;
                        change_n_s = credit_r - CR_ONE;
                        credit_n_s = CR_ZERO;
                        state_n_s  = (credit_r != CR_ONE) ? ST_PAYOUT : ST_IDLE;
                    end else begin
                        credit_n_s = credit_r;
                    end
                end else if (p1 | p5) begin
                    reject_n_s = p1 & p5;
                    if (sum_s < CR_PRICE) begin
                        credit_n_s = sum_s;
                    end else begin
                        dispense_n_s = 1'b1;
                        sales_n_s    = sales_r + SALES_ONE;
                        credit_n_s   = CR_ZERO;
                        if (chg_s != CR_ZERO) begin
                            c1_n_s     = 1'b1;
                            change_n_s = chg_s - CR_ONE;
                            state_n_s  = (chg_s != CR_ONE) ? ST_PAYOUT : ST_IDLE;
                        end else begin
                            change_n_s = CR_ZERO;
                        end
                    end
                end else begin
                    credit_n_s = credit_r;
                end
            end
            ST_PAYOUT: begin
                // Coins are refused while paying out; cancel has no effect.
                c1_n_s     = 1'b1;
                reject_n_s = p1 | p5;
                credit_n_s = CR_ZERO;
                if (change_cnt_r <= CR_ONE) begin
                    change_n_s = CR_ZERO;
                    state_n_s  = ST_IDLE;
                end else begin
                    change_n_s = change_cnt_r - CR_ONE;
                end
            end
            default: begin
                state_n_s  = ST_IDLE;
                credit_n_s = CR_ZERO;
                change_n_s = CR_ZERO;
            end
        endcase
    end

    // State and output registers; reset abandons any payout in progress.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= ST_IDLE;
            credit_r     <= CR_ZERO;
            change_cnt_r <= CR_ZERO;
            sales_r      <= {CNT_W{1'b0}};
            dispense_r   <= 1'b0;
            c1_r         <= 1'b0;
            reject_r     <= 1'b0;
        end else begin
            state_r      <= state_n_s;
            credit_r     <= credit_n_s;
            change_cnt_r <= change_n_s;
            sales_r      <= sales_n_s;
            dispense_r   <= dispense_n_s;
            c1_r         <= c1_n_s;
            reject_r     <= reject_n_s;
        end
    end

    assign dispense = dispense_r;
    assign c1       = c1_r;
    assign reject   = reject_r;
    assign busy     = (state_r == ST_PAYOUT);
    assign credit   = credit_r;
    assign sales    = sales_r;

endmodule

// File: tb/tb_vending_machine_param.sv
// ---------------------------------------------------------------------------
// tb_vending_machine_param
//   Two instances share the same coin/cancel stimulus:
//     dut0: PRICE=3, COIN_HI=5, CNT_W=8
//     dut1: PRICE=1, COIN_HI=1, CNT_W=2 (every coin buys, sales wraps fast)
//   A reference model tracks credit, units owed and sales as plain integers
//   and queues the expected outputs for each edge; a monitor pops and
//   compares one entry per DUT shortly after every rising edge.
// ---------------------------------------------------------------------------
module tb_vending_machine_param;

    typedef struct packed {
        logic       dispense;
        logic       c1;
        logic       reject;
        logic       busy;
        logic [7:0] credit;
        logic [7:0] sales;
    } exp_t;

    logic clk;
    logic reset_n;
    logic p1, p5, cancel;

    logic       d0_dispense, d0_c1, d0_reject, d0_busy;
    logic [3:0] d0_credit;
    logic [7:0] d0_sales;
    logic       d1_dispense, d1_c1, d1_reject, d1_busy;
    logic [1:0] d1_credit;
    logic [1:0] d1_sales;

    vending_machine_param #(.PRICE(3), .COIN_HI(5), .CNT_W(8)) dut0 (
        .clk(clk), .reset_n(reset_n), .p1(p1), .p5(p5), .cancel(cancel),
        .dispense(d0_dispense), .c1(d0_c1), .reject(d0_reject), .busy(d0_busy),
        .credit(d0_credit), .sales(d0_sales)
    );

    vending_machine_param #(.PRICE(1), .COIN_HI(1), .CNT_W(2)) dut1 (
        .clk(clk), .reset_n(reset_n), .p1(p1), .p5(p5), .cancel(cancel),
        .dispense(d1_dispense), .c1(d1_c1), .reject(d1_reject), .busy(d1_busy),
        .credit(d1_credit), .sales(d1_sales)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state: credit held, units still owed, items sold.
    int m_price[2] = '{3, 1};
    int m_coin[2]  = '{5, 1};
    int m_cntw[2]  = '{8, 2};
    int m_credit[2];
    int m_owed[2];
    int m_sales[2];

    exp_t q0[$];
    exp_t q1[$];

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            m_credit[i] = 0;
            m_owed[i]   = 0;
            m_sales[i]  = 0;
        end
    endfunction

    // One clock edge of the vending rules for machine id.
    function automatic exp_t model_step(input int id, input logic i1, input logic i5,
                                        input logic ic);
        exp_t e;
        int   v;
        int   sum;
        e = '0;
        if (m_owed[id] > 0) begin
            e.c1 = 1'b1;
            m_owed[id]--;
            e.reject = i1 | i5;
        end else if (ic) begin
            e.reject = i1 | i5;
            m_owed[id] = m_credit[id];
            m_credit[id] = 0;
            if (m_owed[id] > 0) begin
                e.c1 = 1'b1;
                m_owed[id]--;
            end
        end else if (i1 | i5) begin
            e.reject = i1 & i5;
            v = i1 ? 1 : m_coin[id];
            sum = m_credit[id] + v;
            if (sum < m_price[id]) begin
                m_credit[id] = sum;
            end else begin
                e.dispense = 1'b1;
                m_sales[id] = (m_sales[id] + 1) % (1 << m_cntw[id]);
                m_credit[id] = 0;
                m_owed[id] = sum - m_price[id];
                if (m_owed[id] > 0) begin
                    e.c1 = 1'b1;
                    m_owed[id]--;
                end
            end
        end
        e.busy   = (m_owed[id] > 0);
        e.credit = 8'(m_credit[id]);
        e.sales  = 8'(m_sales[id]);
        return e;
    endfunction

    task automatic cmp(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check(input string who, input exp_t a, input exp_t e);
        cmp({who, ".dispense"}, a.dispense, e.dispense);
        cmp({who, ".c1"},       a.c1,       e.c1);
        cmp({who, ".reject"},   a.reject,   e.reject);
        cmp({who, ".busy"},     a.busy,     e.busy);
        cmp({who, ".credit"},   a.credit,   e.credit);
        cmp({who, ".sales"},    a.sales,    e.sales);
    endtask

    function automatic exp_t act0();
        exp_t a;
        a = {d0_dispense, d0_c1, d0_reject, d0_busy, 8'(d0_credit), d0_sales};
        return a;
    endfunction

    function automatic exp_t act1();
        exp_t a;
        a = {d1_dispense, d1_c1, d1_reject, d1_busy, 8'(d1_credit), 8'(d1_sales)};
        return a;
    endfunction

    // Drive one cycle of inputs and queue what each machine should show after it.
    task automatic cycle(input logic i1, input logic i5, input logic ic);
        @(negedge clk);
        p1 = i1;
        p5 = i5;
        cancel = ic;
        q0.push_back(model_step(0, i1, i5, ic));
        q1.push_back(model_step(1, i1, i5, ic));
    endtask

    // Asynchronous reset between edges; outputs must clear without a clock.
    task automatic do_reset(input string tag);
        @(negedge clk);
        p1 = 1'b0;
        p5 = 1'b0;
        cancel = 1'b0;
        reset_n = 1'b0;
        model_reset();
        #1;
        check({tag, ".dut0"}, act0(), '0);
        check({tag, ".dut1"}, act1(), '0);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Monitor: one expected entry per DUT per rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (q0.size() > 0) check("dut0", act0(), q0.pop_front());
            if (q1.size() > 0) check("dut1", act1(), q1.pop_front());
        end
    end

    initial begin
        reset_n = 1'b0;
        p1 = 1'b0;
        p5 = 1'b0;
        cancel = 1'b0;
        model_reset();
        #12;
        check("por.dut0", act0(), '0);
        check("por.dut1", act1(), '0);
        @(negedge clk);
        reset_n = 1'b1;

        // Three single coins with gaps: credit 1, 2, then a sale with no change.
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b0, 1'b0);
            cycle(1'b0, 1'b0, 1'b0);
        end
        // High coin from empty: dispense plus two units of change.
        cycle(1'b0, 1'b1, 1'b0);
        repeat (3) cycle(1'b0, 1'b0, 1'b0);
        // p1,p1,p5: four units of change, a coin and a cancel during payout.
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1);
        repeat (3) cycle(1'b0, 1'b0, 1'b0);
        // p1,p1 then cancel on dut0; then cancel with a coin at zero credit.
        do_reset("rst1");
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1);
        repeat (3) cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b1);
        cycle(1'b0, 1'b0, 1'b0);
        // Both coins at once, then reset while change is still owed.
        cycle(1'b1, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        do_reset("rst2");
        cycle(1'b0, 1'b1, 1'b0);
        do_reset("rst_payout");
        repeat (3) cycle(1'b0, 1'b0, 1'b0);
        // Run dut1 sales through its 2-bit wrap.
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 1'b0);

        // Randomised traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset("rst_rand");
            end else begin
                cycle(($urandom_range(0, 99) < 30), ($urandom_range(0, 99) < 20),
                      ($urandom_range(0, 99) < 8));
            end
        end
        cycle(1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        if (q0.size() != 0 || q1.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d/%0d entries left, expected 0", q0.size(), q1.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
